// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read and write sides.
// Gray/binary conversion works on a wide word; callers truncate to their width.
package fifo_pkg;

    localparam int ADDR_SIZE = 4;
    localparam int PTR_W     = ADDR_SIZE + 1;
    localparam int FN_W      = 32;

    localparam logic RST_EMPTY     = 1'b1;
    localparam logic RST_AEMPTY    = 1'b1;
    localparam logic RST_UNDERFLOW = 1'b0;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_empty_rd_ctrl_g2b.sv
// Combinational Gray-to-binary converter of arbitrary width.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(FN_W'(i_gray)));

endmodule

// File: rtl/fifo_empty_rd_ctrl.sv
// Read-side pointer, empty/almost-empty, level and sticky underflow
// for the dual-clock FIFO; compares against the synchronized write pointer.
module fifo_empty_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   wr_ptr_addr_sync,
    input  logic                 underflow_clr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 underflow,
    output logic [ADDR_SIZE:0]   rd_addr_grey,
    output logic [ADDR_SIZE-1:0] rd_addr_bin
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] r_rd_bin;
    logic [PW-1:0] r_rd_grey;
    logic          r_empty;
    logic          r_aempty;
    logic [PW-1:0] r_level;
    logic          r_underflow;

    logic          w_rd_fire;
    logic          w_uflow_try;
    logic [PW-1:0] w_rd_bin_next;
    logic [PW-1:0] w_rd_grey_next;
    logic [PW-1:0] w_wr_bin_sync;
    logic [PW-1:0] w_level_next;
    logic          w_empty_next;
    logic          w_aempty_next;

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_wr_g2b (
        .i_gray (wr_ptr_addr_sync),
        .o_bin  (w_wr_bin_sync)
    );

    // Qualify with the registered flag so the read path has no comb loop
    assign w_rd_fire      = rd_en & ~r_empty;
    assign w_uflow_try    = rd_en & r_empty;
    assign w_rd_bin_next  = r_rd_bin + PW'(w_rd_fire);
    assign w_rd_grey_next = PW'(bin2gray(FN_W'(w_rd_bin_next)));
    assign w_empty_next   = (w_rd_grey_next == wr_ptr_addr_sync);
    assign w_level_next   = w_wr_bin_sync - w_rd_bin_next;
    assign w_aempty_next  = (w_level_next <= PW'(AEMPTY_THRESH));

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rd_bin    <= '0;
            r_rd_grey   <= '0;
            r_empty     <= RST_EMPTY;
            r_aempty    <= RST_AEMPTY;
            r_level     <= '0;
            r_underflow <= RST_UNDERFLOW;
        end else begin
            r_rd_bin  <= w_rd_bin_next;
            r_rd_grey <= w_rd_grey_next;
            r_empty   <= w_empty_next;
            r_aempty  <= w_aempty_next;
            r_level   <= w_level_next;
            // A fresh underflow outranks a clear in the same cycle
            if (w_uflow_try) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign rd_level     = r_level;
    assign underflow    = r_underflow;
    assign rd_addr_grey = r_rd_grey;
    assign rd_addr_bin  = r_rd_bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fifo_empty_rd_ctrl.sv
// Scoreboard bench for fifo_empty_rd_ctrl (ADDR_SIZE=4, AEMPTY_THRESH=2).
module tb_fifo_empty_rd_ctrl;

    typedef struct packed {
        logic       e;
        logic       ae;
        logic [4:0] lvl;
        logic       u;
        logic [4:0] g;
        logic [3:0] a;
    } exp_t;

    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [4:0] wr_ptr_addr_sync = '0;
    logic       underflow_clr = 1'b0;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       underflow;
    logic [4:0] rd_addr_grey;
    logic [3:0] rd_addr_bin;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   stim_done = 1'b0;

    always #5 rd_clk = ~rd_clk;

    fifo_empty_rd_ctrl #(
        .ADDR_SIZE     (4),
        .AEMPTY_THRESH (2)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rst           (rd_rst),
        .rd_en            (rd_en),
        .wr_ptr_addr_sync (wr_ptr_addr_sync),
        .underflow_clr    (underflow_clr),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_level         (rd_level),
        .underflow        (underflow),
        .rd_addr_grey     (rd_addr_grey),
        .rd_addr_bin      (rd_addr_bin)
    );

    function automatic logic [4:0] gr(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic exp_t mk(input logic e, input logic ae, input int l,
                                input logic u, input logic [4:0] g,
                                input int a);
        exp_t x;
        x.e = e;
        x.ae = ae;
        x.lvl = 5'(l);
        x.u = u;
        x.g = g;
        x.a = 4'(a);
        return x;
    endfunction

    task automatic step(input logic rst, input logic en, input logic clr,
                        input logic [4:0] wg, input exp_t x);
        @(negedge rd_clk);
        rd_rst = rst;
        rd_en = en;
        underflow_clr = clr;
        wr_ptr_addr_sync = wg;
        q.push_back(x);
    endtask

    // Monitor: one expected tuple per edge, checked 1ns after it
    initial begin
        exp_t x;
        exp_t act;
        forever begin
            @(posedge rd_clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                act = {empty, almost_empty, rd_level, underflow,
                       rd_addr_grey, rd_addr_bin};
                n_total++;
                if (act === x) begin
                    n_pass++;
                end else begin
                    $display("FAIL chk%0d: got e=%b ae=%b lvl=%0d u=%b g=%b a=%0d want e=%b ae=%b lvl=%0d u=%b g=%b a=%0d",
                             n_total, act.e, act.ae, act.lvl, act.u, act.g,
                             act.a, x.e, x.ae, x.lvl, x.u, x.g, x.a);
                end
            end
        end
    end

    initial begin
        // Reset held 3 cycles with rd_en high
        repeat (3) step(1, 1, 0, 5'b00000, mk(1, 1, 0, 0, 5'b00000, 0));

        // Write side arrives: Gray 1, 3, 2 (bin 1, 2, 3)
        step(0, 0, 0, 5'b00001, mk(0, 1, 1, 0, 5'b00000, 0));
        step(0, 0, 0, 5'b00011, mk(0, 1, 2, 0, 5'b00000, 0));
        step(0, 0, 0, 5'b00010, mk(0, 0, 3, 0, 5'b00000, 0));

        // Drain three entries
        step(0, 1, 0, 5'b00010, mk(0, 1, 2, 0, 5'b00001, 1));
        step(0, 1, 0, 5'b00010, mk(0, 1, 1, 0, 5'b00011, 2));
        step(0, 1, 0, 5'b00010, mk(1, 1, 0, 0, 5'b00010, 3));

        // Underflow, set-beats-clear, then clear
        step(0, 1, 0, 5'b00010, mk(1, 1, 0, 1, 5'b00010, 3));
        step(0, 1, 1, 5'b00010, mk(1, 1, 0, 1, 5'b00010, 3));
        step(0, 0, 1, 5'b00010, mk(1, 1, 0, 0, 5'b00010, 3));

        // Almost-empty: wr to bin 7 -> level 4, read to 3 then 2, write to 3
        step(0, 0, 0, 5'b00100, mk(0, 0, 4, 0, 5'b00010, 3));
        step(0, 1, 0, 5'b00100, mk(0, 0, 3, 0, 5'b00110, 4));
        step(0, 1, 0, 5'b00100, mk(0, 1, 2, 0, 5'b00111, 5));
        step(0, 0, 0, 5'b01100, mk(0, 0, 3, 0, 5'b00111, 5));

        // Read and write together each cycle: level holds at 3, rd 5 -> 20
        for (int rp = 6; rp <= 20; rp++) begin
            step(0, 1, 0, gr(rp + 3), mk(0, 0, 3, 0, gr(rp), rp % 16));
        end

        // Writes only: wr 24 -> 36 (mod 32 = 4), level reaches 16 (full)
        for (int wp = 24; wp <= 36; wp++) begin
            step(0, 0, 0, gr(wp), mk(0, 0, wp - 20, 0, 5'b11110, 4));
        end
        step(0, 0, 0, 5'b00110, mk(0, 0, 16, 0, 5'b11110, 4));

        // Empty with wr at Gray 11000 (bin 16): rd at 20 -> wr behind; use rst
        step(1, 1, 0, 5'b00110, mk(1, 1, 0, 0, 5'b00000, 0));
        step(0, 1, 0, 5'b00000, mk(1, 1, 0, 1, 5'b00000, 0));
        step(0, 0, 1, 5'b00000, mk(1, 1, 0, 0, 5'b00000, 0));

        // Advance wr to bin 16 in Gray steps, then read 16 to hit Gray 11000
        for (int wp = 1; wp <= 16; wp++) begin
            step(0, 0, 0, gr(wp), mk(0, (wp <= 2), wp, 0, 5'b00000, 0));
        end
        for (int rp = 1; rp <= 16; rp++) begin
            step(0, 1, 0, 5'b11000,
                 mk((rp == 16), ((16 - rp) <= 2), 16 - rp, 0, gr(rp), rp % 16));
        end
        step(0, 1, 0, 5'b11000, mk(1, 1, 0, 1, 5'b11000, 0));

        stim_done = 1'b1;
        repeat (20) begin
            if (q.size() > 0) @(posedge rd_clk);
        end
        #2;
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks left pending, want 0", q.size());
            n_total += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
